// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//   Integer register file with an operand-hazard scoreboard, sitting between
//   decode/issue and the ALU. Reads are combinational with write-through
//   bypass; a per-register busy bit marks registers with an outstanding write
//   and holds issue while any source or the destination is still pending.
//
// Ports
//   clk, rst_n          core clock (rising edge) and async active-low reset
//   A1, A2 / RD1, RD2   operand read addresses and combinational read data
//   A3, WD3, WE3        write-back port (ALU result or load data)
//   issue_valid         decode presents an instruction (reads A1/A2, writes issue_rd)
//   issue_rd            destination of that instruction, 0 = none
//   issue_stall         instruction must be held this cycle (combinational)
//   busy_cnt            registered number of registers currently pending
// -----------------------------------------------------------------------------
module reg_file_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   A1,
   input  logic [AW-1:0]   A2,
   output logic [XLEN-1:0] RD1,
   output logic [XLEN-1:0] RD2,
   input  logic [AW-1:0]   A3,
   input  logic [XLEN-1:0] WD3,
   input  logic            WE3,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic            issue_stall,
   output logic [AW:0]     busy_cnt
);

   logic [XLEN-1:0] regs_r [NREG];
   logic [NREG-1:0] busy_r;
   logic [AW:0]     busy_cnt_r;

   logic            wr_s;
   logic            stall_s;
   logic            set_s;
   logic            inc_s;
   logic            dec_s;
   logic [XLEN-1:0] rd1_s;
   logic [XLEN-1:0] rd2_s;
   logic [NREG-1:0] busy_nxt_s;

   // A register is a hazard while busy, unless this cycle's write-back clears it.
   function automatic logic hazard(input logic [NREG-1:0] busy,
                                   input logic [AW-1:0]   r,
                                   input logic            wr,
                                   input logic [AW-1:0]   a3);
      return busy[r] && !(wr && (a3 == r));
   endfunction

   // Read one operand: x0 and reset read zero, a same-cycle write is forwarded.
   function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0]   a,
                                                 input logic            rstn,
                                                 input logic            wr,
                                                 input logic [AW-1:0]   a3,
                                                 input logic [XLEN-1:0] wd,
                                                 input logic [XLEN-1:0] stored);
      logic [XLEN-1:0] v;
      if (!rstn || (a == {AW{1'b0}})) begin
         v = {XLEN{1'b0}};
      end else if (wr && (a3 == a)) begin
         v = wd;
      end else begin
         v = stored;
      end
      return v;
   endfunction

   // Write-back qualification, issue stall and scoreboard counter deltas.
   always_comb begin
      wr_s    = WE3 && (A3 != {AW{1'b0}});
      stall_s = rst_n && issue_valid &&
                (hazard(busy_r, A1, wr_s, A3) ||
                 hazard(busy_r, A2, wr_s, A3) ||
                 hazard(busy_r, issue_rd, wr_s, A3));
      set_s   = issue_valid && !stall_s && (issue_rd != {AW{1'b0}});
      // An accepted destination is never busy unless it is being cleared now,
      // so a set only counts when the bit was idle; a clear only counts when
      // the bit was set and the same register is not being re-claimed.
      inc_s   = set_s && !busy_r[issue_rd];
      dec_s   = wr_s && busy_r[A3] && !(set_s && (issue_rd == A3));
   end

   // Next busy vector: clear on write-back, then set on issue so set wins.
   always_comb begin
      busy_nxt_s = busy_r;
      if (wr_s) begin
         busy_nxt_s[A3] = 1'b0;
      end else begin
         busy_nxt_s = busy_nxt_s;
      end
      if (set_s) begin
         busy_nxt_s[issue_rd] = 1'b1;
      end else begin
         busy_nxt_s = busy_nxt_s;
      end
   end

   // Combinational operand reads.
   always_comb begin
      rd1_s = read_port(A1, rst_n, wr_s, A3, WD3, regs_r[A1]);
      rd2_s = read_port(A2, rst_n, wr_s, A3, WD3, regs_r[A2]);
   end

   // Register array storage; writes to x0 are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
         end
      end else if (wr_s) begin
         regs_r[A3] <= WD3;
      end
   end

   // Scoreboard bits and their population count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r     <= {NREG{1'b0}};
         busy_cnt_r <= {(AW+1){1'b0}};
      end else begin
         busy_r <= busy_nxt_s;
         case ({inc_s, dec_s})
            2'b10:   busy_cnt_r <= busy_cnt_r + {{AW{1'b0}}, 1'b1};
            2'b01:   busy_cnt_r <= busy_cnt_r - {{AW{1'b0}}, 1'b1};
            default: busy_cnt_r <= busy_cnt_r;
         endcase
      end
   end

   assign RD1         = rd1_s;
   assign RD2         = rd2_s;
   assign issue_stall = stall_s;
   assign busy_cnt    = busy_cnt_r;

endmodule
